// File: rtl/tl_pkg.sv
// Shared traffic-light types: main FSM states plus the override sequencer states.
package tl_pkg;

    // Main traffic-light FSM states; S8_OVERRIDE requests the sequencer itself.
    typedef enum logic [3:0] {
        S0_A_STRAIGHT    = 4'd0,
        S1_A_YELLOW      = 4'd1,
        S2_A_LEFT        = 4'd2,
        S3_A_LEFT_YELLOW = 4'd3,
        S4_B_STRAIGHT    = 4'd4,
        S5_B_YELLOW      = 4'd5,
        S6_B_LEFT        = 4'd6,
        S7_B_LEFT_YELLOW = 4'd7,
        S8_OVERRIDE      = 4'd8
    } state_t;

    // Override sequencer states.
    typedef enum logic [2:0] {
        OVR_IDLE     = 3'd0,
        OVR_WAIT_MIN = 3'd1,
        OVR_YELLOW   = 3'd2,
        OVR_ALL_RED  = 3'd3,
        OVR_LOAD     = 3'd4,
        OVR_ACK      = 3'd5,
        OVR_COOLDOWN = 3'd6
    } ovr_seq_t;

    // Largest of three durations, used to size the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter for timed phases: load a value, count to zero, hold at zero.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_reg;

    // Reload on phase entry, otherwise count down and stop at zero (no wrap).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/override_sequencer.sv
// Override sequencer: takes a latched jump request, walks the lights through
// yellow and all-red clearance, loads the target state, then enforces a cooldown.
module override_sequencer
    import tl_pkg::*;
#(
    parameter int MIN_GREEN_CYC = 50_000_000,
    parameter int YELLOW_CYC    = 150_000_000,
    parameter int ALLRED_CYC    = 50_000_000,
    parameter int COOLDOWN_CYC  = 250_000_000
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   jump_req,
    input  state_t jump_state,
    input  state_t cur_state,
    input  logic   in_green,
    input  logic   green_entry,
    output logic   accept_jump,
    output logic   ovr_active,
    output logic   ovr_yellow,
    output logic   ovr_all_red,
    output logic   load_en,
    output state_t load_state
);

    localparam int TMR_W = $clog2(max3(YELLOW_CYC, ALLRED_CYC, COOLDOWN_CYC) + 1);
    localparam int GRN_W = $clog2(MIN_GREEN_CYC + 1);

    // Timer is loaded with duration-1 so the state lasts exactly duration cycles.
    localparam logic [TMR_W-1:0] YELLOW_LOAD   = TMR_W'(YELLOW_CYC - 1);
    localparam logic [TMR_W-1:0] ALLRED_LOAD   = TMR_W'(ALLRED_CYC - 1);
    localparam logic [TMR_W-1:0] COOLDOWN_LOAD = TMR_W'(COOLDOWN_CYC - 1);
    localparam logic [GRN_W-1:0] MIN_GREEN     = GRN_W'(MIN_GREEN_CYC);

    ovr_seq_t          state_reg, state_next;
    state_t            target_reg;
    logic              target_load;
    logic [GRN_W-1:0]  green_cnt_reg;
    logic              min_ok;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_done;
    logic              trivial_req;

    phase_timer #(
        .W(TMR_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // Time spent in the current green phase, saturating at the minimum.
    always_ff @(posedge clk) begin
        if (rst) begin
            green_cnt_reg <= '0;
        end else if (green_entry) begin
            green_cnt_reg <= '0;
        end else if (in_green && (green_cnt_reg != MIN_GREEN)) begin
            green_cnt_reg <= green_cnt_reg + 1'b1;
        end
    end

    assign min_ok = (green_cnt_reg >= MIN_GREEN);

    // A request that needs no light change: explicit override, or already there.
    assign trivial_req = (jump_state == S8_OVERRIDE) ||
                         ((jump_state == cur_state) && in_green);

    // Target is captured once when a real sequence starts; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_reg <= S0_A_STRAIGHT;
        end else if (target_load) begin
            target_reg <= jump_state;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= OVR_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the timer is reloaded on every transition into a timed state.
    always_comb begin
        state_next   = state_reg;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        target_load  = 1'b0;
        case (state_reg)
            OVR_IDLE: begin
                if (jump_req) begin
                    if (trivial_req) begin
                        state_next = OVR_ACK;
                    end else begin
                        target_load = 1'b1;
                        if (!in_green) begin
                            state_next   = OVR_ALL_RED;
                            tmr_load     = 1'b1;
                            tmr_load_val = ALLRED_LOAD;
                        end else if (min_ok) begin
                            state_next   = OVR_YELLOW;
                            tmr_load     = 1'b1;
                            tmr_load_val = YELLOW_LOAD;
                        end else begin
                            state_next = OVR_WAIT_MIN;
                        end
                    end
                end
            end
            OVR_WAIT_MIN: begin
                // Green ending on its own skips yellow; nothing left to clear but red.
                if (!in_green) begin
                    state_next   = OVR_ALL_RED;
                    tmr_load     = 1'b1;
                    tmr_load_val = ALLRED_LOAD;
                end else if (min_ok) begin
                    state_next   = OVR_YELLOW;
                    tmr_load     = 1'b1;
                    tmr_load_val = YELLOW_LOAD;
                end
            end
            OVR_YELLOW: begin
                if (tmr_done) begin
                    state_next   = OVR_ALL_RED;
                    tmr_load     = 1'b1;
                    tmr_load_val = ALLRED_LOAD;
                end
            end
            OVR_ALL_RED: begin
                if (tmr_done) begin
                    state_next = OVR_LOAD;
                end
            end
            OVR_LOAD: begin
                state_next   = OVR_COOLDOWN;
                tmr_load     = 1'b1;
                tmr_load_val = COOLDOWN_LOAD;
            end
            OVR_ACK: begin
                state_next = OVR_IDLE;
            end
            OVR_COOLDOWN: begin
                if (tmr_done) begin
                    state_next = OVR_IDLE;
                end
            end
            default: begin
                state_next = OVR_IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        accept_jump = 1'b0;
        ovr_active  = 1'b0;
        ovr_yellow  = 1'b0;
        ovr_all_red = 1'b0;
        load_en     = 1'b0;
        case (state_reg)
            OVR_YELLOW: begin
                ovr_active = 1'b1;
                ovr_yellow = 1'b1;
            end
            OVR_ALL_RED: begin
                ovr_active  = 1'b1;
                ovr_all_red = 1'b1;
            end
            OVR_LOAD: begin
                ovr_active  = 1'b1;
                load_en     = 1'b1;
                accept_jump = 1'b1;
            end
            OVR_ACK: begin
                accept_jump = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign load_state = target_reg;

endmodule

// File: tb/tb_override_sequencer.sv
// Directed bench for override_sequencer with short durations.
module tb_override_sequencer;
    import tl_pkg::*;

    localparam int MIN_G = 8;
    localparam int YEL   = 4;
    localparam int AR    = 2;
    localparam int CD    = 6;

    logic   clk = 1'b0;
    logic   rst;
    logic   jump_req;
    state_t jump_state;
    state_t cur_state;
    logic   in_green;
    logic   green_entry;
    logic   accept_jump;
    logic   ovr_active;
    logic   ovr_yellow;
    logic   ovr_all_red;
    logic   load_en;
    state_t load_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [4:0] outs_v;
    assign outs_v = {accept_jump, ovr_active, ovr_yellow, ovr_all_red, load_en};

    override_sequencer #(
        .MIN_GREEN_CYC (MIN_G),
        .YELLOW_CYC    (YEL),
        .ALLRED_CYC    (AR),
        .COOLDOWN_CYC  (CD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_req    (jump_req),
        .jump_state  (jump_state),
        .cur_state   (cur_state),
        .in_green    (in_green),
        .green_entry (green_entry),
        .accept_jump (accept_jump),
        .ovr_active  (ovr_active),
        .ovr_yellow  (ovr_yellow),
        .ovr_all_red (ovr_all_red),
        .load_en     (load_en),
        .load_state  (load_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {accept, active, yellow, all_red, load} at offset k after the request.
    // ylen < 0 selects the acknowledge-only path.
    function automatic logic [4:0] exp_outs(input int k, input int b, input int ylen);
        int r;
        if (ylen < 0) return (k == 1) ? 5'b10000 : 5'b00000;
        r = b + ylen;
        if (k >= b && k < r)          return 5'b01100;
        if (k >= r && k < r + AR)     return 5'b01010;
        if (k == r + AR)              return 5'b11001;
        return 5'b00000;
    endfunction

    // Raise a request at the current cycle and check n following cycles.
    // The button interface drops jump_req the cycle after it sees accept_jump.
    task automatic run_seq(input string tag, input state_t req_st, input int b, input int ylen,
                           input state_t exp_ld, input int n, input int inj_at, input state_t inj_st);
        bit acc_seen;
        acc_seen   = 1'b0;
        jump_req   = 1'b1;
        jump_state = req_st;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (acc_seen) jump_req = 1'b0;
            if (k == inj_at) begin
                jump_req   = 1'b1;
                jump_state = inj_st;
            end
            check_eq($sformatf("%s outs@T+%0d", tag, k), 32'(outs_v), 32'(exp_outs(k, b, ylen)));
            if (ylen >= 0 && k == b + ylen + AR)
                check_eq($sformatf("%s load_state", tag), 32'(load_state), 32'(exp_ld));
            acc_seen = accept_jump;
        end
        $display("[TB] %s: %0d cycles checked", tag, n);
    endtask

    initial begin
        rst         = 1'b1;
        jump_req    = 1'b0;
        jump_state  = S0_A_STRAIGHT;
        cur_state   = S0_A_STRAIGHT;
        in_green    = 1'b0;
        green_entry = 1'b0;

        // Reset held 3 cycles, then 20 quiet cycles.
        repeat (3) tick();
        check_eq("reset outs", 32'(outs_v), 32'd0);
        check_eq("reset load_state", 32'(load_state), 32'(S0_A_STRAIGHT));
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq($sformatf("idle outs@%0d", i), 32'(outs_v), 32'd0);
        end
        $display("[TB] reset/idle: done");

        // Green phase long enough to satisfy the minimum.
        in_green    = 1'b1;
        green_entry = 1'b1;
        tick();
        green_entry = 1'b0;
        repeat (20) tick();

        // Normal sequence to S4; jump_state change mid-yellow must not alter the target.
        run_seq("norm_s4", S4_B_STRAIGHT, 1, YEL, S4_B_STRAIGHT, 14, 2, S6_B_LEFT);

        // Request two cycles into a fresh green: waits for minimum green.
        green_entry = 1'b1;
        tick();
        green_entry = 1'b0;
        tick();
        run_seq("wait_min_s6", S6_B_LEFT, 8, YEL, S6_B_LEFT, 21, -1, S0_A_STRAIGHT);

        // Already in the requested green: acknowledge only.
        cur_state = S2_A_LEFT;
        run_seq("ack_same", S2_A_LEFT, 0, -1, S0_A_STRAIGHT, 4, -1, S0_A_STRAIGHT);

        // Explicit override request: acknowledge only.
        cur_state = S0_A_STRAIGHT;
        run_seq("ack_s8", S8_OVERRIDE, 0, -1, S0_A_STRAIGHT, 4, -1, S0_A_STRAIGHT);

        // Not in green: straight to all-red clearance.
        in_green = 1'b0;
        run_seq("no_green_s4", S4_B_STRAIGHT, 1, 0, S4_B_STRAIGHT, 10, -1, S0_A_STRAIGHT);
        in_green = 1'b1;

        // New request during cooldown is held off until IDLE.
        run_seq("cool_a", S4_B_STRAIGHT, 1, YEL, S4_B_STRAIGHT, 13, 10, S2_A_LEFT);
        tick();
        check_eq("cool idle", 32'(outs_v), 32'd0);
        run_seq("cool_b", S2_A_LEFT, 1, YEL, S2_A_LEFT, 14, -1, S0_A_STRAIGHT);

        // Reset in the second yellow cycle; held request restarts from IDLE with a cleared green count.
        run_seq("rst_pre", S4_B_STRAIGHT, 1, YEL, S4_B_STRAIGHT, 2, -1, S0_A_STRAIGHT);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst mid-yellow outs", 32'(outs_v), 32'd0);
        check_eq("rst mid-yellow target", 32'(load_state), 32'(S0_A_STRAIGHT));
        run_seq("rst_post", S4_B_STRAIGHT, 9, YEL, S4_B_STRAIGHT, 22, -1, S0_A_STRAIGHT);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
